// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-RAM arbiter
//
// Purpose: FSM state encoding and requester index constants used by
//          dmem_arbiter and arb_pick2.
// Ports:   none (package).
// Config:  DMEM_ARB_RR_EN selects round-robin arbitration inside arb_pick2.

package dmem_arbiter_pkg;

   // Transaction FSM: one grant takes exactly IDLE -> ACCESS -> RESP.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   // Requester indices (grant_idx / rr_ptr encoding).
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_pick2.sv
// rtl/dmem_arbiter_pick2.sv - two-way combinational grant selector
//
// Purpose: chooses which of two pending requests is served next.
// Ports:
//   req[1:0]     in   pending requests, bit n = port n
//   rr_ptr       in   preferred port (round-robin build only)
//   grant_idx    out  index of the selected port
//   grant_valid  out  1 when any request is pending
// Config:
//   DMEM_ARB_RR_EN defined   : rr_ptr port wins a tie
//   DMEM_ARB_RR_EN undefined : port 0 always wins a tie, rr_ptr ignored

module arb_pick2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_ptr,
   output logic       grant_idx,
   output logic       grant_valid
);

`ifdef DMEM_ARB_RR_EN
   always_comb begin
      grant_valid = |req;
      // Preferred port if it asks, otherwise the other one. When nothing
      // is pending the index is don't-care because grant_valid is 0.
      grant_idx   = req[rr_ptr] ? rr_ptr : ~rr_ptr;
   end
`else
   logic unused_rr_ptr;
   assign unused_rr_ptr = rr_ptr;

   always_comb begin
      grant_valid = |req;
      grant_idx   = req[0] ? PORT0 : PORT1;
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port 256x64 data RAM between two requesters
//
// Purpose: serialises port 0 (CPU load/store) and port 1 (debug/DMA loader)
//          onto one falling-edge-sampled RAM, one transaction at a time.
//          Every grant takes three cycles: IDLE (sample), ACCESS (RAM acts on
//          the mid-cycle falling edge), RESP (one-cycle ack to the winner).
// Ports:
//   clock, reset               clock; synchronous active-high reset
//   pN_req/write/addr/wdata    requester N command (level request, held to ack)
//   pN_ack, pN_rdata           requester N completion pulse and read data
//                              (a store returns the word's previous contents)
//   ram_address/write/in       registered RAM command
//   ram_out                    RAM read data
//   busy                       1 whenever a transaction is in flight
// Config:
//   DMEM_ARB_RR_EN             round-robin instead of fixed port-0 priority
//                              (resolved inside arb_pick2)

module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
)
(
   input  logic              clock,
   input  logic              reset,

   input  logic              p0_req,
   input  logic              p0_write,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,

   input  logic              p1_req,
   input  logic              p1_write,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,

   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_in,
   input  logic [DATA_W-1:0] ram_out,

   output logic              busy
);

   state_t state;
   logic   win;          // port that owns the in-flight transaction
   logic   rr_ptr;       // preferred port for the next tie
   logic   grant_idx;
   logic   grant_valid;

   arb_pick2 u_pick (
      .req         ({p1_req, p0_req}),
      .rr_ptr      (rr_ptr),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   assign busy = (state != S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         win         <= PORT0;
         rr_ptr      <= PORT0;
         ram_address <= '0;
         ram_write   <= 1'b0;
         ram_in      <= '0;
         p0_ack      <= 1'b0;
         p1_ack      <= 1'b0;
         p0_rdata    <= '0;
         p1_rdata    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               p0_ack    <= 1'b0;
               p1_ack    <= 1'b0;
               ram_write <= 1'b0;
               if (grant_valid) begin
                  win    <= grant_idx;
                  rr_ptr <= ~grant_idx;
                  if (grant_idx == PORT1) begin
                     ram_address <= p1_addr;
                     ram_write   <= p1_write;
                     ram_in      <= p1_wdata;
                  end else begin
                     ram_address <= p0_addr;
                     ram_write   <= p0_write;
                     ram_in      <= p0_wdata;
                  end
                  state <= S_ACCESS;
               end
            end

            S_ACCESS: begin
               // The RAM has already acted on this cycle's falling edge, so
               // ram_out holds the word as it was before any store.
               ram_write <= 1'b0;
               if (win == PORT1) begin
                  p1_rdata <= ram_out;
                  p1_ack   <= 1'b1;
               end else begin
                  p0_rdata <= ram_out;
                  p0_ack   <= 1'b1;
               end
               state <= S_RESP;
            end

            S_RESP: begin
               p0_ack <= 1'b0;
               p1_ack <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
               p0_ack    <= 1'b0;
               p1_ack    <= 1'b0;
               ram_write <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
